// File: rtl/bsg_axi_bus_pkg.sv
// Shared AXI constants, FSM state types and bus-width helpers for the memory slave.
package bsg_axi_bus_pkg;

  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;
  localparam logic [1:0] resp_decerr = 2'b11;

  localparam logic [1:0] burst_fixed = 2'b00;
  localparam logic [1:0] burst_incr  = 2'b01;
  localparam logic [1:0] burst_wrap  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Flat widths of the packed mosi/miso structs declared in the slave.
  function automatic int mosi_width(int id_w, int addr_w, int data_w);
    return 2 * (id_w + addr_w + 30) + data_w + data_w / 8 + 4;
  endfunction

  function automatic int miso_width(int id_w, int data_w);
    return 2 * id_w + data_w + 10;
  endfunction

  // Decode error outranks slave error.
  function automatic logic [1:0] resp_of(logic dec, logic err);
    return dec ? resp_decerr : (err ? resp_slverr : resp_okay);
  endfunction

endpackage

// File: rtl/axi_mem_slave_array.sv
// Word array with one byte-enabled synchronous write port and one asynchronous read port.
module axi_mem_slave_array #(
  parameter  int els_p    = 1024,
  parameter  int width_p  = 512,
  localparam int idx_w_lp = $clog2(els_p),
  localparam int bytes_lp = width_p / 8
) (
  input  logic                clk_i,
  input  logic                w_en_i,
  input  logic [idx_w_lp-1:0] w_idx_i,
  input  logic [width_p-1:0]  w_data_i,
  input  logic [bytes_lp-1:0] w_mask_i,
  input  logic [idx_w_lp-1:0] r_idx_i,
  output logic [width_p-1:0]  r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_en_i) begin
      for (int unsigned b = 0; b < bytes_lp; b++) begin
        if (w_mask_i[b]) mem[w_idx_i][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  assign r_data_o = mem[r_idx_i];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent INCR-only read and write engines over a byte-enabled word array.
module axi_mem_slave
  import bsg_axi_bus_pkg::*;
#(
  parameter  int id_width_p    = 6,
  parameter  int addr_width_p  = 64,
  parameter  int data_width_p  = 512,
  parameter  int mem_els_p     = 1024,
  localparam int mosi_width_lp = mosi_width(id_width_p, addr_width_p, data_width_p),
  localparam int miso_width_lp = miso_width(id_width_p, data_width_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [mosi_width_lp-1:0] s_axi_bus_i,
  output logic [miso_width_lp-1:0] s_axi_bus_o
);

  localparam int off_lp   = $clog2(data_width_p / 8);
  localparam int idx_w_lp = $clog2(mem_els_p);
  localparam int strb_lp  = data_width_p / 8;
  localparam logic [2:0] size_lp = 3'(off_lp);

  typedef struct packed {
    logic [id_width_p-1:0]   awid;
    logic [addr_width_p-1:0] awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic [data_width_p-1:0] wdata;
    logic [strb_lp-1:0]      wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [id_width_p-1:0]   arid;
    logic [addr_width_p-1:0] araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    rready;
  } mosi_s;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [id_width_p-1:0]   bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    arready;
    logic [id_width_p-1:0]   rid;
    logic [data_width_p-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } miso_s;

  mosi_s mosi;
  miso_s miso;
  assign mosi = s_axi_bus_i;
  assign s_axi_bus_o = miso;

  function automatic logic out_of_range(input logic [addr_width_p-1:0] addr);
    return (addr >> (off_lp + idx_w_lp)) != '0;
  endfunction

  logic unused_ok;
  assign unused_ok = ^{mosi.awlock, mosi.awcache, mosi.awprot, mosi.awqos, mosi.awregion,
                       mosi.awaddr[off_lp-1:0], mosi.arlock, mosi.arcache, mosi.arprot,
                       mosi.arqos, mosi.arregion, mosi.araddr[off_lp-1:0]};

  w_state_e w_state_r, w_state_n;
  logic [id_width_p-1:0] w_id_r;
  logic [idx_w_lp-1:0]   w_idx_r;
  logic [7:0]            w_len_r, w_cnt_r;
  logic                  w_err_r, w_dec_r;
  logic                  aw_ready, w_ready, b_valid, mem_we;
  logic [id_width_p-1:0] b_id;
  logic [1:0]            b_resp;

  r_state_e r_state_r, r_state_n;
  logic [id_width_p-1:0]   r_id_r;
  logic [idx_w_lp-1:0]     r_idx_r;
  logic [7:0]              r_len_r, r_cnt_r;
  logic                    r_err_r, r_dec_r;
  logic                    ar_ready, r_valid, r_last;
  logic [id_width_p-1:0]   r_id;
  logic [data_width_p-1:0] r_data, mem_rdata;
  logic [1:0]              r_resp;

  logic w_final;
  assign w_final = (w_cnt_r == w_len_r);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_state_r <= W_IDLE;
      w_id_r    <= '0;
      w_idx_r   <= '0;
      w_len_r   <= '0;
      w_cnt_r   <= '0;
      w_err_r   <= 1'b0;
      w_dec_r   <= 1'b0;
    end else begin
      w_state_r <= w_state_n;
      if (aw_ready && mosi.awvalid) begin
        w_id_r  <= mosi.awid;
        w_idx_r <= mosi.awaddr[off_lp +: idx_w_lp];
        w_len_r <= mosi.awlen;
        w_cnt_r <= '0;
        w_err_r <= (mosi.awburst != burst_incr) || (mosi.awsize != size_lp);
        w_dec_r <= out_of_range(mosi.awaddr);
      end else if (w_ready && mosi.wvalid) begin
        w_idx_r <= w_idx_r + 1'b1;
        w_cnt_r <= w_cnt_r + 1'b1;
        if (mosi.wlast != w_final) w_err_r <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_n = w_state_r;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_id      = '0;
    b_resp    = resp_okay;
    mem_we    = 1'b0;
    unique case (w_state_r)
      W_IDLE: begin
        aw_ready = !reset_i;
        if (mosi.awvalid && !reset_i) w_state_n = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        mem_we  = mosi.wvalid && !w_err_r && !w_dec_r;
        if (mosi.wvalid && w_final) w_state_n = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        b_id    = w_id_r;
        b_resp  = resp_of(w_dec_r, w_err_r);
        if (mosi.bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state_r <= R_IDLE;
      r_id_r    <= '0;
      r_idx_r   <= '0;
      r_len_r   <= '0;
      r_cnt_r   <= '0;
      r_err_r   <= 1'b0;
      r_dec_r   <= 1'b0;
    end else begin
      r_state_r <= r_state_n;
      if (ar_ready && mosi.arvalid) begin
        r_id_r  <= mosi.arid;
        r_idx_r <= mosi.araddr[off_lp +: idx_w_lp];
        r_len_r <= mosi.arlen;
        r_cnt_r <= '0;
        r_err_r <= (mosi.arburst != burst_incr) || (mosi.arsize != size_lp);
        r_dec_r <= out_of_range(mosi.araddr);
      end else if (r_valid && mosi.rready) begin
        r_idx_r <= r_idx_r + 1'b1;
        r_cnt_r <= r_cnt_r + 1'b1;
      end
    end
  end

  always_comb begin
    r_state_n = r_state_r;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_id      = '0;
    r_data    = '0;
    r_resp    = resp_okay;
    r_last    = 1'b0;
    unique case (r_state_r)
      R_IDLE: begin
        ar_ready = !reset_i;
        if (mosi.arvalid && !reset_i) r_state_n = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        r_id    = r_id_r;
        r_data  = r_dec_r ? '0 : mem_rdata;
        r_resp  = resp_of(r_dec_r, r_err_r);
        r_last  = (r_cnt_r == r_len_r);
        if (mosi.rready && r_last) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  assign miso = '{aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
                  r_id, r_data, r_resp, r_last, r_valid};

  axi_mem_slave_array #(
    .els_p   (mem_els_p),
    .width_p (data_width_p)
  ) array (
    .clk_i    (clk_i),
    .w_en_i   (mem_we),
    .w_idx_i  (w_idx_r),
    .w_data_i (mosi.wdata),
    .w_mask_i (mosi.wstrb),
    .r_idx_i  (r_idx_r),
    .r_data_o (mem_rdata)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave with a bench-side memory model and R/B scoreboards.
module tb_axi_mem_slave;

  localparam int ID = 6;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [ID-1:0] awid; logic [AW-1:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0] awburst; logic awlock; logic [3:0] awcache; logic [2:0] awprot;
    logic [3:0] awqos; logic [3:0] awregion; logic awvalid;
    logic [DW-1:0] wdata; logic [SW-1:0] wstrb; logic wlast; logic wvalid;
    logic bready;
    logic [ID-1:0] arid; logic [AW-1:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0] arburst; logic arlock; logic [3:0] arcache; logic [2:0] arprot;
    logic [3:0] arqos; logic [3:0] arregion; logic arvalid;
    logic rready;
  } mosi_s;

  typedef struct packed {
    logic awready; logic wready; logic [ID-1:0] bid; logic [1:0] bresp; logic bvalid;
    logic arready; logic [ID-1:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp;
    logic rlast; logic rvalid;
  } miso_s;

  typedef struct packed { logic [DW-1:0] data; logic [ID-1:0] id; logic [1:0] resp; logic last; } rexp_t;
  typedef struct packed { logic [ID-1:0] id; logic [1:0] resp; } bexp_t;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  mosi_s mosi;
  miso_s miso;

  rexp_t rq[$];
  bexp_t bq[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] model [1024];
  logic [DW-1:0] last_rdata;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  axi_mem_slave #(
    .id_width_p   (ID),
    .addr_width_p (AW),
    .data_width_p (DW),
    .mem_els_p    (1024)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .s_axi_bus_i (mosi),
    .s_axi_bus_o (miso)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] s);
    return {16{s}};
  endfunction

  // Compare one R beat against the scoreboard head.
  task automatic r_pop_check();
    rexp_t e;
    e = rq.pop_front();
    chk("rdata", miso.rdata, e.data);
    chk("rid", DW'(miso.rid), DW'(e.id));
    chk("rresp", DW'(miso.rresp), DW'(e.resp));
    chk1("rlast", miso.rlast, e.last);
    last_rdata = miso.rdata;
  endtask

  task automatic write_burst(input logic [ID-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int last_at, input logic [SW-1:0] strb,
                             input logic [1:0] exp_resp);
    logic [9:0] idx;
    logic [DW-1:0] d;
    bexp_t e;
    int n;
    idx = addr[15:6];
    bq.push_back('{id, exp_resp});
    mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len; mosi.awsize = 3'd6;
    mosi.awburst = burst; mosi.awvalid = 1'b1;
    #1;
    n = 0;
    while (!miso.awready && n < 50) begin tick(); n++; end
    chk1("awready", miso.awready, 1'b1);
    tick();
    mosi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d = wq.pop_front();
      mosi.wvalid = 1'b1; mosi.wdata = d; mosi.wstrb = strb; mosi.wlast = (i == last_at);
      #1;
      chk1("wready", miso.wready, 1'b1);
      if (exp_resp == OKAY)
        for (int b = 0; b < SW; b++) if (strb[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      idx++;
      tick();
    end
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
    #1;
    chk1("bvalid_latency", miso.bvalid, 1'b1);
    e = bq.pop_front();
    chk("bid", DW'(miso.bid), DW'(e.id));
    chk("bresp", DW'(miso.bresp), DW'(e.resp));
    mosi.bready = 1'b1;
    tick();
    chk1("bvalid_clear", miso.bvalid, 1'b0);
  endtask

  task automatic read_burst(input logic [ID-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] exp_resp, input bit rand_ready);
    logic [9:0] idx;
    logic [DW-1:0] hold_data;
    logic hold_last;
    int got, n;
    bit stalled;
    idx = addr[15:6];
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{(exp_resp == DECERR) ? '0 : model[idx], id, exp_resp, (i == int'(len))});
      idx++;
    end
    mosi.arid = id; mosi.araddr = addr; mosi.arlen = len; mosi.arsize = 3'd6;
    mosi.arburst = INCR; mosi.arvalid = 1'b1;
    #1;
    n = 0;
    while (!miso.arready && n < 50) begin tick(); n++; end
    chk1("arready", miso.arready, 1'b1);
    tick();
    mosi.arvalid = 1'b0;
    #1;
    chk1("rvalid_latency", miso.rvalid, 1'b1);
    chk1("arready_busy", miso.arready, 1'b0);
    got = 0; n = 0; stalled = 1'b0; hold_data = '0; hold_last = 1'b0;
    while (got <= int'(len) && n < 400) begin
      mosi.rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!rand_ready) chk1("rvalid_stream", miso.rvalid, 1'b1);
      if (miso.rvalid) begin
        if (stalled) begin
          chk("r_stable_data", miso.rdata, hold_data);
          chk1("r_stable_last", miso.rlast, hold_last);
        end
        if (mosi.rready) begin
          r_pop_check();
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_data = miso.rdata; hold_last = miso.rlast;
        end
      end
      tick();
      n++;
    end
    chk("r_beats", DW'(got), DW'(int'(len) + 1));
    mosi.rready = 1'b0;
    #1;
    chk1("arready_next", miso.arready, 1'b1);
  endtask

  initial begin
    int wb, rgot;
    bit bdone, stalled;
    logic [DW-1:0] hold_data;
    bexp_t be;

    mosi = '0;
    #2 reset_i = 1'b1;
    #1;
    chk1("reset_miso_zero", (miso == '0), 1'b1);
    tick(); tick();
    chk1("reset_held_miso_zero", (miso == '0), 1'b1);
    reset_i = 1'b0;
    #1;
    chk1("idle_awready", miso.awready, 1'b1);
    chk1("idle_arready", miso.arready, 1'b1);

    // Basic 4-beat write and read-back.
    for (int i = 0; i < 4; i++) wq.push_back(pat(32'hD000_0000 + 32'(i)));
    write_burst(6'd5, 64'h40, 8'd3, INCR, 3, '1, OKAY);
    read_burst(6'd9, 64'h40, 8'd3, OKAY, 1'b0);

    // Byte strobe merge on word 7.
    wq.push_back('1);
    write_burst(6'd1, 64'(7 * 64), 8'd0, INCR, 0, '1, OKAY);
    wq.push_back('0);
    write_burst(6'd1, 64'(7 * 64), 8'd0, INCR, 0, 64'hF, OKAY);
    read_burst(6'd2, 64'(7 * 64), 8'd0, OKAY, 1'b0);
    chk("strobe_merge", last_rdata, {{60{8'hFF}}, 32'h0});

    // Index wrap from the top word back to word 0.
    wq.push_back(pat(32'hAAAA_0001));
    wq.push_back(pat(32'hBBBB_0002));
    write_burst(6'd3, 64'(1023 * 64), 8'd1, INCR, 1, '1, OKAY);
    read_burst(6'd4, 64'(1023 * 64), 8'd0, OKAY, 1'b0);
    chk("wrap_top", last_rdata, pat(32'hAAAA_0001));
    read_burst(6'd4, 64'h0, 8'd0, OKAY, 1'b0);
    chk("wrap_zero", last_rdata, pat(32'hBBBB_0002));

    // WRAP burst is rejected with SLVERR and leaves the array alone.
    wq.push_back(pat(32'h1111_0200));
    wq.push_back(pat(32'h1111_0201));
    write_burst(6'd6, 64'(200 * 64), 8'd1, INCR, 1, '1, OKAY);
    wq.push_back(pat(32'hDEAD_0000));
    wq.push_back(pat(32'hDEAD_0001));
    write_burst(6'd6, 64'(200 * 64), 8'd1, WRAP, 1, '1, SLVERR);
    read_burst(6'd7, 64'(200 * 64), 8'd1, OKAY, 1'b0);
    chk("wrap_err_untouched", last_rdata, pat(32'h1111_0201));

    // Out-of-range address decodes to DECERR with zero data.
    read_burst(6'd8, (64'h1 << 20) | 64'h40, 8'd0, DECERR, 1'b0);
    chk("decerr_rdata", last_rdata, '0);

    // Early wlast.
    wq.push_back(pat(32'h3000_0000));
    wq.push_back(pat(32'h3000_0001));
    write_burst(6'd10, 64'(300 * 64), 8'd1, INCR, 0, '1, SLVERR);

    // Preload words 100..115.
    for (int i = 0; i < 16; i++) wq.push_back(pat(32'h5100_0000 + 32'(i)));
    write_burst(6'd2, 64'(100 * 64), 8'd15, INCR, 15, '1, OKAY);

    // 16-beat read with concurrent 4-beat write under random backpressure.
    for (int i = 0; i < 16; i++) rq.push_back('{model[100 + i], 6'd3, OKAY, (i == 15)});
    bq.push_back('{6'd4, OKAY});
    mosi.arid = 6'd3; mosi.araddr = 64'(100 * 64); mosi.arlen = 8'd15; mosi.arsize = 3'd6;
    mosi.arburst = INCR; mosi.arvalid = 1'b1;
    mosi.awid = 6'd4; mosi.awaddr = 64'(500 * 64); mosi.awlen = 8'd3; mosi.awsize = 3'd6;
    mosi.awburst = INCR; mosi.awvalid = 1'b1;
    #1;
    chk1("conc_arready", miso.arready, 1'b1);
    chk1("conc_awready", miso.awready, 1'b1);
    tick();
    mosi.arvalid = 1'b0; mosi.awvalid = 1'b0;
    wb = 0; rgot = 0; bdone = 1'b0; stalled = 1'b0; hold_data = '0;
    for (int c = 0; c < 300 && !(rgot == 16 && bdone); c++) begin
      mosi.rready = 1'($urandom_range(0, 1));
      mosi.bready = 1'($urandom_range(0, 1));
      mosi.wvalid = (wb < 4);
      mosi.wdata = pat(32'hC0DE_0000 + 32'(wb));
      mosi.wstrb = '1;
      mosi.wlast = (wb == 3);
      #1;
      if (miso.rvalid) begin
        if (stalled) chk("conc_r_stable", miso.rdata, hold_data);
        if (mosi.rready) begin
          r_pop_check();
          rgot++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_data = miso.rdata;
        end
      end
      if (mosi.wvalid && miso.wready) begin
        model[500 + wb] = mosi.wdata;
        wb++;
      end
      if (miso.bvalid && mosi.bready && !bdone) begin
        be = bq.pop_front();
        chk("conc_bid", DW'(miso.bid), DW'(be.id));
        chk("conc_bresp", DW'(miso.bresp), DW'(be.resp));
        bdone = 1'b1;
      end
      tick();
    end
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.rready = 1'b0; mosi.bready = 1'b1;
    chk("conc_r_beats", DW'(rgot), DW'(16));
    chk1("conc_b_done", bdone, 1'b1);
    chk("conc_w_beats", DW'(wb), DW'(4));
    read_burst(6'd11, 64'(500 * 64), 8'd3, OKAY, 1'b0);

    // Reset during beat 2 of an 8-beat read.
    for (int i = 0; i < 8; i++) rq.push_back('{model[100 + i], 6'd7, OKAY, (i == 7)});
    mosi.arid = 6'd7; mosi.araddr = 64'(100 * 64); mosi.arlen = 8'd7; mosi.arsize = 3'd6;
    mosi.arburst = INCR; mosi.arvalid = 1'b1;
    #1;
    chk1("rst_arready", miso.arready, 1'b1);
    tick();
    mosi.arvalid = 1'b0; mosi.rready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk1("rst_pre_rvalid", miso.rvalid, 1'b1);
      r_pop_check();
      tick();
    end
    reset_i = 1'b1;
    #1;
    chk1("rst_rvalid_drop", miso.rvalid, 1'b0);
    chk1("rst_miso_zero", (miso == '0), 1'b1);
    tick();
    reset_i = 1'b0;
    mosi.rready = 1'b0;
    rq.delete();
    #1;
    chk1("post_rst_arready", miso.arready, 1'b1);
    chk1("post_rst_awready", miso.awready, 1'b1);
    read_burst(6'd12, 64'(102 * 64), 8'd1, OKAY, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- Single-port AXI4 (full) memory slave for the master side of the slot aggregation crossbar.
- Consumes the one aggregated master bus and backs it with an internal byte-enabled word array.
- Serves as the simulation and bring-up endpoint in place of DDR.
- Independent read and write engines; INCR bursts only; bus-width beats only.

Parameters:
- id_width_p, "inv", AXI ID width; must match the upstream crossbar.
- addr_width_p, "inv", AXI address width.
- data_width_p, "inv", AXI data width; power of two, >= 32.
- mem_els_p, 1024, number of data_width_p-wide words; power of two.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- s_axi_bus_i  input  `bsg_axi_mosi_bus_width(1,id_width_p,addr_width_p,data_width_p)  packed mosi struct from the master.
- s_axi_bus_o  output  `bsg_axi_miso_bus_width(1,id_width_p,addr_width_p,data_width_p)  packed miso struct to the master.

Behaviour:
- Reset: write FSM W_IDLE, read FSM R_IDLE. All miso fields are 0 while reset_i is high, including awready, wready, bvalid, arready, rvalid, bid, bresp, rid, rdata, rresp and rlast. Array contents are not reset.
- Word index: idx = addr[lg(data_width_p/8) +: lg(mem_els_p)].
  - Low byte-offset bits are ignored.
  - Upper address bits beyond the index: request is still accepted and completes normally, but its response is DECERR (2'b11). A DECERR write does not touch the array; a DECERR read returns rdata=0.
- Error precedence for a burst: DECERR > SLVERR > OKAY.
- Write FSM:
  - W_IDLE: awready=1 when reset_i is low. On AW handshake, capture awid, idx, awlen; clear beat_cnt and the err flag. Set err if awburst!=2'b01 (INCR) or awsize!=lg(data_width_p/8). Go to W_DATA.
  - W_DATA: wready=1. Each W handshake:
    - Write byte lanes with wstrb set to mem[idx], unless err or DECERR.
    - idx increments modulo mem_els_p (wraps silently); beat_cnt increments.
    - The burst ends when beat_cnt==awlen. Set err if wlast != (beat_cnt==awlen) on any beat.
    - On the final beat go to W_RESP.
  - W_RESP: bvalid=1, bid=captured awid, bresp=OKAY(00) / SLVERR(10) / DECERR(11). On B handshake go to W_IDLE. bvalid and bid/bresp hold stable until bready.
  - awready=0 outside W_IDLE, so exactly one write burst is outstanding.
- Read FSM:
  - R_IDLE: arready=1 when reset_i is low. On AR handshake, capture arid, idx, arlen; err = (arburst!=INCR or arsize mismatch). Go to R_DATA.
  - R_DATA: rvalid=1, rid=captured arid, rdata=mem[idx] (combinational read of registered idx), rresp per err/DECERR, rlast=(beat_cnt==arlen).
  - On R handshake: idx++ mod mem_els_p, beat_cnt++. On the rlast beat go to R_IDLE.
  - R-channel payload holds stable while rvalid && !rready.
  - An SLVERR read still returns arlen+1 beats, with rdata=mem contents.
- Latency: AR handshake in cycle t gives first rvalid in cycle t+1. With rready held high, one beat per cycle. AW accepted at t gives wready at t+1. Last W beat at t gives bvalid at t+1.
- Simultaneous read and write to the same word in one cycle: read returns the old data; the write takes effect next cycle.
- Read and write engines never stall each other.
- awready/arready are never asserted at the same time as the engine's busy state (no back-to-back overlap). Next AR is accepted in the cycle after the final R handshake.
- Reset asserted mid-burst: both FSMs return to idle immediately and all miso fields drop to 0. Partial writes already made remain in the array.

Decomposition:
- bsg_axi_bus_pkg (shared): localparams for resp codes (OKAY, SLVERR, DECERR) and burst codes (FIXED, INCR, WRAP); typedef enums for the write and read FSM states.
- Bus structs: declared via `declare_bsg_axi_bus_s(1, ...).
- Sub-module axi_mem_slave_array: mem_els_p x data_width_p array with one byte-enabled synchronous write port, one asynchronous read port, and no reset.

Test Plan (data_width_p=512, mem_els_p=1024, id_width_p=6, addr_width_p=64):
- AW id=5, addr=0x40, len=3, INCR, size=6; 4 W beats with data D0..D3, full strobe; bready=1. Expected: bvalid one cycle after the last W beat, bid=5, bresp=00. Then AR id=9, addr=0x40, len=3. Expected: R beats D0..D3 in consecutive cycles, rid=9, rlast only on beat 3, rresp=00.
- Write word 7 with all-ones. Then write word 7 with 0x00 data and wstrb=0x0F. Read word 7. Expected: bytes 0..3 = 0x00, all other bytes 0xFF.
- AW addr=(mem_els_p-1)*64, len=1; write A, B. Read idx 1023 and idx 0. Expected: A at idx 1023, B at idx 0 (wrap-around).
- Error cases:
  - AW with awburst=WRAP, len=1: both beats accepted, bresp=10, array unchanged.
  - AR with addr bit 20 set: rresp=11, rdata=0.
  - W with wlast on beat 0 of a len=1 burst: bresp=10.
- Random rready/bready backpressure during a 16-beat read with a concurrent write. Expected: R payload stable while stalled; read data matches a pre-loaded pattern; no lost beats.
- Assert reset_i during beat 2 of an 8-beat read. Expected: rvalid=0 in the same cycle. After release, arready=1 and a new read completes normally.
